// File: rtl/tmds_deserializer.sv
// TMDS serial-to-parallel deserializer with control-token word alignment.
// Optional lock-loss monitor enabled by defining TMDS_DESER_LOCK_MONITOR_EN.
module tmds_deserializer #(
    parameter int VERIFY_COUNT = 4,
    parameter int LOSS_WORDS   = 1024
) (
    input  logic       clk_tmds,
    input  logic       rst_n,
    input  logic       data_i,
    output logic [9:0] data_o,
    output logic       data_valid_o,
    output logic       token_o,
    output logic       locked_o
);

    localparam logic [1:0] SEARCH = 2'd0;
    localparam logic [1:0] VERIFY = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    localparam logic [3:0] VERIFY_TARGET = 4'(VERIFY_COUNT);

    if (VERIFY_COUNT < 1 || VERIFY_COUNT > 15) begin : g_bad_verify_count
        $error("tmds_deserializer: VERIFY_COUNT must be 1..15");
    end
    if (LOSS_WORDS < 2 || LOSS_WORDS > 65535) begin : g_bad_loss_words
        $error("tmds_deserializer: LOSS_WORDS must be 2..65535");
    end

    logic [9:0] window;
    logic [3:0] fill_cnt;
    logic [3:0] phase;
    logic [3:0] hit_cnt;
    logic [3:0] hit_next;
    logic [1:0] state;
    logic       window_valid;
    logic       boundary;
    logic       is_token;

    assign window_valid = (fill_cnt == 4'd10);
    assign boundary     = (phase == 4'd0);
    assign hit_next     = hit_cnt + 4'd1;
    assign locked_o     = (state == LOCKED);

    always_comb begin
        is_token = 1'b0;
        case (window)
            10'b1101010100,
            10'b0010101011,
            10'b0101010100,
            10'b1010101011: is_token = 1'b1;
            default:        is_token = 1'b0;
        endcase
    end

    // Window shifts toward bit 0 so the first-received bit of a word ends at bit 0.
    always_ff @(posedge clk_tmds or negedge rst_n) begin
        if (!rst_n) begin
            window   <= 10'd0;
            fill_cnt <= 4'd0;
        end else begin
            window <= {data_i, window[9:1]};
            if (fill_cnt != 4'd10) begin
                fill_cnt <= fill_cnt + 4'd1;
            end
        end
    end

    // Phase 0 marks a cycle where the window holds a complete aligned word.
    always_ff @(posedge clk_tmds or negedge rst_n) begin
        if (!rst_n) begin
            phase <= 4'd0;
        end else if (state == SEARCH && window_valid && is_token) begin
            phase <= 4'd1;
        end else if (phase == 4'd9) begin
            phase <= 4'd0;
        end else begin
            phase <= phase + 4'd1;
        end
    end

`ifdef TMDS_DESER_LOCK_MONITOR_EN
    localparam logic [15:0] LOSS_TARGET = 16'(LOSS_WORDS);
    logic [15:0] loss_cnt;
    logic [15:0] loss_next;
    assign loss_next = loss_cnt + 16'd1;
`endif

    always_ff @(posedge clk_tmds or negedge rst_n) begin
        if (!rst_n) begin
            state        <= SEARCH;
            hit_cnt      <= 4'd0;
            data_o       <= 10'd0;
            data_valid_o <= 1'b0;
            token_o      <= 1'b0;
`ifdef TMDS_DESER_LOCK_MONITOR_EN
            loss_cnt     <= 16'd0;
`endif
        end else begin
            data_valid_o <= 1'b0;
            token_o      <= 1'b0;
            case (state)
                SEARCH: begin
                    if (window_valid && is_token) begin
                        hit_cnt <= 4'd1;
                        state   <= (VERIFY_TARGET == 4'd1) ? LOCKED : VERIFY;
                    end
                end
                VERIFY: begin
                    if (boundary) begin
                        if (is_token) begin
                            hit_cnt <= hit_next;
                            if (hit_next == VERIFY_TARGET) begin
                                state <= LOCKED;
                            end
                        end else begin
                            hit_cnt <= 4'd0;
                            state   <= SEARCH;
                        end
                    end
                end
                LOCKED: begin
                    if (boundary) begin
                        data_o       <= window;
                        data_valid_o <= 1'b1;
                        token_o      <= is_token;
`ifdef TMDS_DESER_LOCK_MONITOR_EN
                        if (is_token) begin
                            loss_cnt <= 16'd0;
                        end else if (loss_next == LOSS_TARGET) begin
                            loss_cnt <= 16'd0;
                            hit_cnt  <= 4'd0;
                            state    <= SEARCH;
                        end else begin
                            loss_cnt <= loss_next;
                        end
`endif
                    end
                end
                default: begin
                    hit_cnt <= 4'd0;
                    state   <= SEARCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tmds_deserializer.sv
// Directed self-checking bench for tmds_deserializer (VERIFY_COUNT=4 and =1 instances).
// Lock-loss checks adapt to whether TMDS_DESER_LOCK_MONITOR_EN is defined.
module tb_tmds_deserializer;

    localparam logic [9:0] TOK  = 10'b1101010100;
    localparam logic [9:0] DATA = 10'h1F0;
    localparam logic [9:0] NTOK = 10'h155;

    logic       clk_tmds = 1'b0;
    logic       rst_n;
    logic       data_i;
    logic [9:0] data_o, data1_o;
    logic       data_valid_o, data_valid1_o;
    logic       token_o, token1_o;
    logic       locked_o, locked1_o;

    int checks = 0;
    int errors = 0;

    tmds_deserializer #(.VERIFY_COUNT(4), .LOSS_WORDS(16)) dut (
        .clk_tmds(clk_tmds), .rst_n(rst_n), .data_i(data_i), .data_o(data_o),
        .data_valid_o(data_valid_o), .token_o(token_o), .locked_o(locked_o)
    );

    tmds_deserializer #(.VERIFY_COUNT(1), .LOSS_WORDS(16)) dut1 (
        .clk_tmds(clk_tmds), .rst_n(rst_n), .data_i(data_i), .data_o(data1_o),
        .data_valid_o(data_valid1_o), .token_o(token1_o), .locked_o(locked1_o)
    );

    always #5 clk_tmds = ~clk_tmds;

    typedef struct {
        int         at;
        logic [9:0] data;
        logic       token;
    } strobe_t;

    int      edge_cnt = 0;
    int      base = 0;
    strobe_t log_q[$];
    strobe_t log1_q[$];
    int      lock_at = -1;
    int      lock1_at = -1;
    int      unlock_at = -1;
    logic    prev_lock = 1'b0;
    logic    prev_lock1 = 1'b0;

    always @(posedge clk_tmds) edge_cnt <= edge_cnt + 1;

    // Strobes and lock transitions are logged with the clk edge count seen at the following negedge.
    always @(negedge clk_tmds) begin
        if (data_valid_o === 1'b1) log_q.push_back('{edge_cnt, data_o, token_o});
        if (data_valid1_o === 1'b1) log1_q.push_back('{edge_cnt, data1_o, token1_o});
        if (locked_o === 1'b1 && !prev_lock && lock_at < 0) lock_at = edge_cnt;
        if (locked_o === 1'b0 && prev_lock && unlock_at < 0) unlock_at = edge_cnt;
        if (locked1_o === 1'b1 && !prev_lock1 && lock1_at < 0) lock1_at = edge_cnt;
        prev_lock  = (locked_o === 1'b1);
        prev_lock1 = (locked1_o === 1'b1);
    end

    task automatic send_bit(input logic b);
        data_i = b;
        @(negedge clk_tmds);
    endtask

    task automatic send_word(input logic [9:0] w);
        for (int i = 0; i < 10; i++) send_bit(w[i]);
    endtask

    task automatic start_test;
        base = edge_cnt;
        log_q.delete();
        log1_q.delete();
        lock_at = -1;
        lock1_at = -1;
        unlock_at = -1;
    endtask

    task automatic apply_reset;
        @(negedge clk_tmds);
        rst_n  = 1'b0;
        data_i = 1'b0;
        repeat (3) @(negedge clk_tmds);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n  = 1'b0;
        data_i = 1'b0;
        repeat (3) @(negedge clk_tmds);
        checks += 4;
        if (data_o !== 10'd0) begin errors++; $display("[TB] FAIL reset_data got %h want 000", data_o); end
        if (data_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", data_valid_o); end
        if (token_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_token got %b want 0", token_o); end
        if (locked_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_locked got %b want 0", locked_o); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic(input int junk);
        logic [2:0] junk_bits;
        junk_bits = 3'b101;
        apply_reset();
        start_test();
        for (int i = 0; i < junk; i++) send_bit(junk_bits[i]);
        repeat (8) send_word(TOK);
        repeat (2) send_word(DATA);
        repeat (3) @(negedge clk_tmds);
        checks += 4;
        if (lock_at - base !== 41 + junk) begin
            errors++; $display("[TB] FAIL basic_lock_time junk=%0d got %0d want %0d", junk, lock_at - base, 41 + junk);
        end
        if (log_q.size() !== 6) begin
            errors++; $display("[TB] FAIL basic_strobe_count junk=%0d got %0d want 6", junk, log_q.size());
        end
        if (lock1_at - base !== 11 + junk) begin
            errors++; $display("[TB] FAIL basic_lock1_time junk=%0d got %0d want %0d", junk, lock1_at - base, 11 + junk);
        end
        if (log1_q.size() !== 9) begin
            errors++; $display("[TB] FAIL basic_strobe1_count junk=%0d got %0d want 9", junk, log1_q.size());
        end
        for (int i = 0; i < 6 && i < log_q.size(); i++) begin
            checks++;
            if (log_q[i].at - base !== 51 + junk + 10 * i || log_q[i].data !== ((i < 4) ? TOK : DATA)
                || log_q[i].token !== (i < 4)) begin
                errors++;
                $display("[TB] FAIL basic_strobe[%0d] junk=%0d got t=%0d d=%h k=%b want t=%0d d=%h k=%b", i, junk,
                         log_q[i].at - base, log_q[i].data, log_q[i].token, 51 + junk + 10 * i,
                         (i < 4) ? TOK : DATA, i < 4);
            end
        end
        for (int i = 0; i < 9 && i < log1_q.size(); i++) begin
            checks++;
            if (log1_q[i].at - base !== 21 + junk + 10 * i || log1_q[i].data !== ((i < 7) ? TOK : DATA)
                || log1_q[i].token !== (i < 7)) begin
                errors++;
                $display("[TB] FAIL basic_strobe1[%0d] junk=%0d got t=%0d d=%h k=%b", i, junk,
                         log1_q[i].at - base, log1_q[i].data, log1_q[i].token);
            end
        end
    endtask

    task automatic test_verify_fail;
        apply_reset();
        start_test();
        repeat (2) send_word(TOK);
        send_word(NTOK);
        repeat (5) send_word(TOK);
        repeat (3) @(negedge clk_tmds);
        checks += 3;
        if (lock_at - base !== 71) begin
            errors++; $display("[TB] FAIL verify_fail_lock_time got %0d want 71", lock_at - base);
        end
        if (log_q.size() !== 1) begin
            errors++; $display("[TB] FAIL verify_fail_strobe_count got %0d want 1", log_q.size());
        end else if (log_q[0].at - base !== 81 || log_q[0].data !== TOK || log_q[0].token !== 1'b1) begin
            errors++;
            $display("[TB] FAIL verify_fail_strobe got t=%0d d=%h k=%b want t=81 d=354 k=1",
                     log_q[0].at - base, log_q[0].data, log_q[0].token);
        end
        if (log1_q.size() < 2) begin
            errors++; $display("[TB] FAIL verify_fail_ntok1 got %0d strobes want >=2", log1_q.size());
        end else if (log1_q[1].at - base !== 31 || log1_q[1].data !== NTOK || log1_q[1].token !== 1'b0) begin
            errors++;
            $display("[TB] FAIL verify_fail_ntok1 got t=%0d d=%h k=%b want t=31 d=155 k=0",
                     log1_q[1].at - base, log1_q[1].data, log1_q[1].token);
        end
    endtask

    task automatic test_reset_mid_lock;
        apply_reset();
        start_test();
        repeat (5) send_word(TOK);
        for (int i = 0; i < 5; i++) send_bit(TOK[i]);
        rst_n = 1'b0;
        #1;
        checks += 6;
        if (log_q.size() !== 1) begin errors++; $display("[TB] FAIL midlock_pre_strobes got %0d want 1", log_q.size()); end
        if (data_o !== 10'd0) begin errors++; $display("[TB] FAIL midlock_data got %h want 000", data_o); end
        if (data_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL midlock_valid got %b want 0", data_valid_o); end
        if (token_o !== 1'b0) begin errors++; $display("[TB] FAIL midlock_token got %b want 0", token_o); end
        if (locked_o !== 1'b0) begin errors++; $display("[TB] FAIL midlock_locked got %b want 0", locked_o); end
        if (locked1_o !== 1'b0) begin errors++; $display("[TB] FAIL midlock_locked1 got %b want 0", locked1_o); end
        repeat (2) @(negedge clk_tmds);
        rst_n = 1'b1;
        repeat (5) send_bit(1'b0);
        checks++;
        if (log_q.size() !== 1 || locked_o !== 1'b0) begin
            errors++; $display("[TB] FAIL midlock_post_release strobes=%0d locked=%b want 1,0", log_q.size(), locked_o);
        end
        apply_reset();
        start_test();
        repeat (5) send_word(TOK);
        repeat (3) @(negedge clk_tmds);
        checks += 2;
        if (lock_at - base !== 41) begin
            errors++; $display("[TB] FAIL midlock_relock_time got %0d want 41", lock_at - base);
        end
        if (log_q.size() !== 1) begin
            errors++; $display("[TB] FAIL midlock_relock_strobes got %0d want 1", log_q.size());
        end
    endtask

    task automatic test_loss;
        apply_reset();
        start_test();
        repeat (4) send_word(TOK);
        repeat (17) send_word(DATA);
        repeat (3) @(negedge clk_tmds);
`ifdef TMDS_DESER_LOCK_MONITOR_EN
        checks += 3;
        if (unlock_at - base !== 201) begin
            errors++; $display("[TB] FAIL loss_unlock_time got %0d want 201", unlock_at - base);
        end
        if (log_q.size() !== 16) begin
            errors++; $display("[TB] FAIL loss_strobe_count got %0d want 16", log_q.size());
        end
        if (locked_o !== 1'b0) begin
            errors++; $display("[TB] FAIL loss_locked_end got %b want 0", locked_o);
        end
        apply_reset();
        start_test();
        repeat (4) send_word(TOK);
        repeat (15) send_word(DATA);
        send_word(TOK);
        repeat (2) send_word(DATA);
        repeat (3) @(negedge clk_tmds);
        checks += 2;
        if (unlock_at !== -1) begin
            errors++; $display("[TB] FAIL loss_keep_unlock got %0d want -1", unlock_at);
        end
        if (locked_o !== 1'b1) begin
            errors++; $display("[TB] FAIL loss_keep_locked got %b want 1", locked_o);
        end
`else
        checks += 3;
        if (unlock_at !== -1) begin
            errors++; $display("[TB] FAIL noloss_unlock got %0d want -1", unlock_at);
        end
        if (locked_o !== 1'b1) begin
            errors++; $display("[TB] FAIL noloss_locked got %b want 1", locked_o);
        end
        if (log_q.size() !== 17) begin
            errors++; $display("[TB] FAIL noloss_strobe_count got %0d want 17", log_q.size());
        end
        for (int i = 0; i < 17 && i < log_q.size(); i++) begin
            checks++;
            if (log_q[i].at - base !== 51 + 10 * i || log_q[i].data !== DATA || log_q[i].token !== 1'b0) begin
                errors++;
                $display("[TB] FAIL noloss_strobe[%0d] got t=%0d d=%h k=%b want t=%0d d=1f0 k=0", i,
                         log_q[i].at - base, log_q[i].data, log_q[i].token, 51 + 10 * i);
            end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic(0);
        test_basic(3);
        test_verify_fail();
        test_reset_mid_lock();
        test_loss();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
